// File: rtl/engine_cmd_queue.sv
// Per-engine command FIFO with a two-state issue FSM that hands one command at
// a time to the NTT engine over a start/done handshake.
module engine_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_opcode,
   input  logic [3:0]       in_slot,
   input  logic [47:0]      in_dma_addr,
   output logic             in_ready,
   input  logic             flush,
   output logic             eng_start,
   output logic [7:0]       eng_opcode,
   output logic [3:0]       eng_slot,
   output logic [47:0]      eng_dma_addr,
   input  logic             eng_done,
   output logic             queue_idle,
   output logic [PTR_W:0]   level,
   output logic [CNT_W-1:0] issued_count,
   output logic             overflow_err,
   output logic             spurious_done_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam int ENTRY_W = 60;
   localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] head;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             eng_start_q, eng_start_d;
   logic [7:0]       eng_opcode_q, eng_opcode_d;
   logic [3:0]       eng_slot_q, eng_slot_d;
   logic [47:0]      eng_dma_addr_q, eng_dma_addr_d;
   logic [CNT_W-1:0] issued_count_q, issued_count_d;
   logic             overflow_q, overflow_d;
   logic             spurious_q, spurious_d;

   logic full, push, pop, done_ok;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      eng_start_d    = 1'b0;
      eng_opcode_d   = eng_opcode_q;
      eng_slot_d     = eng_slot_q;
      eng_dma_addr_d = eng_dma_addr_q;
      issued_count_d = issued_count_q;

      full    = (level_q == FULL_LEVEL);
      head    = mem_q[rd_ptr_q];
      push    = in_valid && !full && !flush;
      pop     = (state_q == IDLE) && (level_q != '0) && !flush;
      // A done seen in the same cycle as the start pulse cannot belong to this command.
      done_ok = eng_done && (state_q == BUSY) && !eng_start_q;

      overflow_d = overflow_q | (in_valid && full && !flush);
      spurious_d = spurious_q | (eng_done && !done_ok);

      unique case (state_q)
         IDLE: begin
            if (pop) begin
               state_d        = BUSY;
               eng_start_d    = 1'b1;
               eng_opcode_d   = head[59:52];
               eng_slot_d     = head[51:48];
               eng_dma_addr_d = head[47:0];
               issued_count_d = issued_count_q + 1'b1;
            end
         end
         BUSY: begin
            if (done_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         eng_start_q    <= 1'b0;
         eng_opcode_q   <= '0;
         eng_slot_q     <= '0;
         eng_dma_addr_q <= '0;
         issued_count_q <= '0;
         overflow_q     <= 1'b0;
         spurious_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         eng_start_q    <= eng_start_d;
         eng_opcode_q   <= eng_opcode_d;
         eng_slot_q     <= eng_slot_d;
         eng_dma_addr_q <= eng_dma_addr_d;
         issued_count_q <= issued_count_d;
         overflow_q     <= overflow_d;
         spurious_q     <= spurious_d;
      end
   end

   // NOTE: FIFO storage has no reset; pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_opcode, in_slot, in_dma_addr};
   end

   assign in_ready          = !full;
   assign queue_idle        = (level_q == '0) && (state_q == IDLE);
   assign level             = level_q;
   assign eng_start         = eng_start_q;
   assign eng_opcode        = eng_opcode_q;
   assign eng_slot          = eng_slot_q;
   assign eng_dma_addr      = eng_dma_addr_q;
   assign issued_count      = issued_count_q;
   assign overflow_err      = overflow_q;
   assign spurious_done_err = spurious_q;

endmodule

// File: tb/tb_engine_cmd_queue.sv
// Directed bench for engine_cmd_queue: a per-cycle vector table plus hand-written
// sequences for async reset, pointer wrap ordering and flush of a full queue.
module tb_engine_cmd_queue;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_opcode = '0;
   logic [3:0]  in_slot = '0;
   logic [47:0] in_dma_addr = '0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        eng_start;
   logic [7:0]  eng_opcode;
   logic [3:0]  eng_slot;
   logic [47:0] eng_dma_addr;
   logic        eng_done = 1'b0;
   logic        queue_idle;
   logic [2:0]  level;
   logic [15:0] issued_count;
   logic        overflow_err;
   logic        spurious_done_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   engine_cmd_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_opcode(in_opcode), .in_slot(in_slot),
      .in_dma_addr(in_dma_addr), .in_ready(in_ready), .flush(flush),
      .eng_start(eng_start), .eng_opcode(eng_opcode), .eng_slot(eng_slot),
      .eng_dma_addr(eng_dma_addr), .eng_done(eng_done), .queue_idle(queue_idle),
      .level(level), .issued_count(issued_count), .overflow_err(overflow_err),
      .spurious_done_err(spurious_done_err)
   );

   typedef struct {
      logic        v;
      logic [7:0]  op;
      logic [3:0]  sl;
      logic [47:0] ad;
      logic        fl;
      logic        dn;
      logic        e_st;
      logic [7:0]  e_op;
      logic [3:0]  e_sl;
      logic [47:0] e_ad;
      logic [2:0]  e_lvl;
      logic        e_idl;
      logic [15:0] e_cnt;
      logic        e_ovf;
      logic        e_spr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [7:0] op, input logic [3:0] sl,
                               input logic [47:0] ad, input logic fl, input logic dn,
                               input logic st, input logic [7:0] eop, input logic [3:0] esl,
                               input logic [47:0] ead, input logic [2:0] lvl, input logic idl,
                               input logic [15:0] cnt, input logic ovf, input logic spr);
      vec_t r;
      r.v = v; r.op = op; r.sl = sl; r.ad = ad; r.fl = fl; r.dn = dn;
      r.e_st = st; r.e_op = eop; r.e_sl = esl; r.e_ad = ead; r.e_lvl = lvl;
      r.e_idl = idl; r.e_cnt = cnt; r.e_ovf = ovf; r.e_spr = spr;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " eng_start"}, 64'(eng_start), 64'd0);
      check({tag, " eng_opcode"}, 64'(eng_opcode), 64'd0);
      check({tag, " eng_slot"}, 64'(eng_slot), 64'd0);
      check({tag, " eng_dma_addr"}, 64'(eng_dma_addr), 64'd0);
      check({tag, " level"}, 64'(level), 64'd0);
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      check({tag, " queue_idle"}, 64'(queue_idle), 64'd1);
      check({tag, " issued_count"}, 64'(issued_count), 64'd0);
      check({tag, " overflow_err"}, 64'(overflow_err), 64'd0);
      check({tag, " spurious_err"}, 64'(spurious_done_err), 64'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [47:0] got[$];
      int          timer;
      int          pushed;
      logic        seen;

      // Single command, fill/overflow, drain with simultaneous push/pop, flush, errors.
      vecs.push_back(mk(Y,8'h01,4'd3,48'h1000,N,N, N,8'h00,4'd0,48'h0,   3'd1,N,16'd0,N,N)); // 0
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h01,4'd3,48'h1000,3'd0,N,16'd1,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h01,4'd3,48'h1000,3'd0,N,16'd1,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h01,4'd3,48'h1000,3'd0,N,16'd1,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h01,4'd3,48'h1000,3'd0,N,16'd1,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h01,4'd3,48'h1000,3'd0,N,16'd1,N,N)); // 5
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h01,4'd3,48'h1000,3'd0,Y,16'd1,N,N));
      vecs.push_back(mk(Y,8'h10,4'd1,48'hA0, N,N, N,8'h01,4'd3,48'h1000,3'd1,N,16'd1,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h10,4'd1,48'hA0,  3'd0,N,16'd2,N,N));
      vecs.push_back(mk(Y,8'h11,4'd2,48'hA1, N,N, N,8'h10,4'd1,48'hA0,  3'd1,N,16'd2,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h10,4'd1,48'hA0,  3'd1,N,16'd2,N,N)); // 10
      vecs.push_back(mk(Y,8'h12,4'd3,48'hA2, N,N, N,8'h10,4'd1,48'hA0,  3'd2,N,16'd2,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h10,4'd1,48'hA0,  3'd2,N,16'd2,N,N));
      vecs.push_back(mk(Y,8'h13,4'd4,48'hA3, N,N, N,8'h10,4'd1,48'hA0,  3'd3,N,16'd2,N,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h10,4'd1,48'hA0,  3'd3,N,16'd2,N,N));
      vecs.push_back(mk(Y,8'h14,4'd5,48'hA4, N,N, N,8'h10,4'd1,48'hA0,  3'd4,N,16'd2,N,N)); // 15
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h10,4'd1,48'hA0,  3'd4,N,16'd2,N,N));
      vecs.push_back(mk(Y,8'h15,4'd6,48'hA5, N,N, N,8'h10,4'd1,48'hA0,  3'd4,N,16'd2,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h10,4'd1,48'hA0,  3'd4,N,16'd2,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h11,4'd2,48'hA1,  3'd3,N,16'd3,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h11,4'd2,48'hA1,  3'd3,N,16'd3,Y,N)); // 20
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h11,4'd2,48'hA1,  3'd3,N,16'd3,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h12,4'd3,48'hA2,  3'd2,N,16'd4,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h12,4'd3,48'hA2,  3'd2,N,16'd4,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h12,4'd3,48'hA2,  3'd2,N,16'd4,Y,N));
      vecs.push_back(mk(Y,8'h16,4'd7,48'hB0, N,N, Y,8'h13,4'd4,48'hA3,  3'd2,N,16'd5,Y,N)); // 25
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h13,4'd4,48'hA3,  3'd2,N,16'd5,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h13,4'd4,48'hA3,  3'd2,N,16'd5,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h14,4'd5,48'hA4,  3'd1,N,16'd6,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h14,4'd5,48'hA4,  3'd1,N,16'd6,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h14,4'd5,48'hA4,  3'd1,N,16'd6,Y,N)); // 30
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h16,4'd7,48'hB0,  3'd0,N,16'd7,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h16,4'd7,48'hB0,  3'd0,N,16'd7,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h16,4'd7,48'hB0,  3'd0,Y,16'd7,Y,N));
      vecs.push_back(mk(Y,8'h20,4'd8,48'hC0, N,N, N,8'h16,4'd7,48'hB0,  3'd1,N,16'd7,Y,N));
      vecs.push_back(mk(Y,8'h21,4'd9,48'hC1, N,N, Y,8'h20,4'd8,48'hC0,  3'd1,N,16'd8,Y,N)); // 35
      vecs.push_back(mk(Y,8'h22,4'hA,48'hC2, N,N, N,8'h20,4'd8,48'hC0,  3'd2,N,16'd8,Y,N));
      vecs.push_back(mk(Y,8'h23,4'hB,48'hC3, N,N, N,8'h20,4'd8,48'hC0,  3'd3,N,16'd8,Y,N));
      vecs.push_back(mk(Y,8'h24,4'hC,48'hC4, Y,N, N,8'h20,4'd8,48'hC0,  3'd0,N,16'd8,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h20,4'd8,48'hC0,  3'd0,Y,16'd8,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h20,4'd8,48'hC0,  3'd0,Y,16'd8,Y,N)); // 40
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, N,8'h20,4'd8,48'hC0,  3'd0,Y,16'd8,Y,N));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h20,4'd8,48'hC0,  3'd0,Y,16'd8,Y,Y));
      vecs.push_back(mk(Y,8'h30,4'hD,48'hD0, N,N, N,8'h20,4'd8,48'hC0,  3'd1,N,16'd8,Y,Y));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,N, Y,8'h30,4'hD,48'hD0,  3'd0,N,16'd9,Y,Y));
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h30,4'hD,48'hD0,  3'd0,N,16'd9,Y,Y)); // 45
      vecs.push_back(mk(N,8'h00,4'd0,48'h0,  N,Y, N,8'h30,4'hD,48'hD0,  3'd0,Y,16'd9,Y,Y));

      tick();
      tick();
      rst = 1'b0;
      check_reset_values("reset");

      foreach (vecs[i]) begin
         in_valid    = vecs[i].v;
         in_opcode   = vecs[i].op;
         in_slot     = vecs[i].sl;
         in_dma_addr = vecs[i].ad;
         flush       = vecs[i].fl;
         eng_done    = vecs[i].dn;
         tick();
         check($sformatf("v%0d eng_start", i), 64'(eng_start), 64'(vecs[i].e_st));
         check($sformatf("v%0d eng_opcode", i), 64'(eng_opcode), 64'(vecs[i].e_op));
         check($sformatf("v%0d eng_slot", i), 64'(eng_slot), 64'(vecs[i].e_sl));
         check($sformatf("v%0d eng_dma_addr", i), 64'(eng_dma_addr), 64'(vecs[i].e_ad));
         check($sformatf("v%0d level", i), 64'(level), 64'(vecs[i].e_lvl));
         check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_lvl != 3'd4));
         check($sformatf("v%0d queue_idle", i), 64'(queue_idle), 64'(vecs[i].e_idl));
         check($sformatf("v%0d issued_count", i), 64'(issued_count), 64'(vecs[i].e_cnt));
         check($sformatf("v%0d overflow_err", i), 64'(overflow_err), 64'(vecs[i].e_ovf));
         check($sformatf("v%0d spurious_err", i), 64'(spurious_done_err), 64'(vecs[i].e_spr));
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      eng_done = 1'b0;

      // Asynchronous reset while BUSY, then a late done from the abandoned command.
      in_valid    = 1'b1;
      in_opcode   = 8'h40;
      in_slot     = 4'h2;
      in_dma_addr = 48'hE0;
      tick();
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         seen = eng_start;
      end
      check("rst-seq issue seen", 64'(seen), 64'd1);
      check("rst-seq issued addr", 64'(eng_dma_addr), 64'hE0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async rst");
      tick();
      rst = 1'b0;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("late done spurious", 64'(spurious_done_err), 64'd1);
      check("late done idle", 64'(queue_idle), 64'd1);
      check("late done no start", 64'(eng_start), 64'd0);

      // Ten commands through a depth-4 FIFO with a 3-cycle engine: order across pointer wraps.
      pulse_reset();
      timer  = 0;
      pushed = 0;
      in_opcode = 8'h55;
      in_slot   = 4'h5;
      for (int cyc = 0; cyc < 300; cyc++) begin
         tick();
         eng_done = 1'b0;
         if (timer > 0) begin
            timer--;
            if (timer == 0) eng_done = 1'b1;
         end
         if (eng_start) begin
            got.push_back(eng_dma_addr);
            timer = 3;
         end
         in_valid    = (pushed < 10) && in_ready;
         in_dma_addr = 48'(pushed);
         if (in_valid) pushed++;
         if (got.size() == 10 && timer == 0 && !eng_done) break;
      end
      in_valid = 1'b0;
      eng_done = 1'b0;
      check("wrap issue count seen", 64'(got.size()), 64'd10);
      for (int i = 0; i < got.size(); i++)
         check($sformatf("wrap order %0d", i), 64'(got[i]), 64'(i));
      check("wrap issued_count", 64'(issued_count), 64'd10);
      check("wrap queue_idle", 64'(queue_idle), 64'd1);
      check("wrap overflow_err", 64'(overflow_err), 64'd0);
      check("wrap spurious_err", 64'(spurious_done_err), 64'd0);

      // Fill to DEPTH behind a busy engine, then flush together with a push at full.
      pulse_reset();
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_dma_addr = 48'(16'h100 + k);
         tick();
      end
      check("fill level", 64'(level), 64'd4);
      check("fill in_ready", 64'(in_ready), 64'd0);
      check("fill overflow_err", 64'(overflow_err), 64'd0);
      in_dma_addr = 48'h1FF;
      flush = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush-full level", 64'(level), 64'd0);
      check("flush-full in_ready", 64'(in_ready), 64'd1);
      check("flush-full no overflow", 64'(overflow_err), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("flush-full no start %0d", k), 64'(eng_start), 64'd0);
      end
      check("flush-full in-flight addr", 64'(eng_dma_addr), 64'h100);
      check("flush-full issued_count", 64'(issued_count), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/engine_cmd_queue.md
Name: engine_cmd_queue

Overview:
- Per-engine command buffer sitting directly downstream of the command processor. One instance per engine core.
- Accepts single-cycle command pulses (opcode/slot/DMA address) and buffers them in a FIFO. Issues them to the NTT engine one at a time with a start/done handshake.
- Drives the engine_ready signal the command processor samples before fetching, so the fetcher is decoupled from engine execution latency.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).
- CNT_W, 16, width of the issued-command counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  one-cycle command pulse from the command processor
- in_opcode  input  8  command opcode
- in_slot  input  4  command slot
- in_dma_addr  input  48  command DMA address
- in_ready  output  1  space available (to the command processor's engine_ready_N)
- flush  input  1  synchronous clear of queued (not in-flight) entries
- eng_start  output  1  one-cycle start pulse to the engine
- eng_opcode  output  8  opcode of the in-flight command
- eng_slot  output  4  slot of the in-flight command
- eng_dma_addr  output  48  address of the in-flight command
- eng_done  input  1  one-cycle completion pulse from the engine
- queue_idle  output  1  FIFO empty and no command in flight
- level  output  PTR_W+1  current FIFO occupancy, 0..DEPTH
- issued_count  output  CNT_W  commands issued since reset; wraps
- overflow_err  output  1  sticky: push arrived while full
- spurious_done_err  output  1  sticky: eng_done arrived while not BUSY

Behaviour:
- Reset values:
  - All outputs 0, except in_ready=1 and queue_idle=1.
  - FIFO pointers 0 and FSM in IDLE.
  - FIFO data contents are don't-care.
- Storage: circular FIFO of 60-bit entries {opcode, slot, addr}. Read/write pointers PTR_W bits wrap modulo DEPTH. Occupancy is held in a separate PTR_W+1 counter.
- in_ready: combinational, equal to (level < DEPTH), derived from registered level only. No path from in_valid.
- Push: in_valid=1 and level<DEPTH at the clock edge writes the entry and increments the write pointer.
- Overflow: in_valid=1 with level==DEPTH drops the command and sets overflow_err. A pop in the same cycle does not rescue the push.
- Issue FSM, 2 states:
  - IDLE: if level>0 and flush=0, pop the head entry into the eng_* registers, pulse eng_start for exactly 1 cycle, increment issued_count, go to BUSY.
  - BUSY: eng_start=0; eng_* outputs hold stable. On eng_done=1, go to IDLE.
  - Minimum gap from done to the next eng_start is 1 cycle (IDLE re-evaluates on the next edge). Back-to-back issue interval = engine latency + 2 cycles.
- Same-cycle push and pop: level unchanged; both pointers advance.
- Push into an empty FIFO while IDLE: the entry is issued on the following edge (first-word latency: in_valid edge to eng_start high = 2 edges).
- eng_done while IDLE, or coincident with eng_start assertion: ignored for FSM purposes; sets spurious_done_err.
- flush:
  - Clears level and both pointers.
  - Has priority over a same-cycle push (push discarded, no overflow flag) and suppresses a same-cycle issue.
  - Does not affect BUSY; the in-flight command completes normally.
  - Sticky errors are cleared only by rst.
- queue_idle = (level==0) && (state==IDLE), registered-source combinational.
- issued_count wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-operation: asynchronous return to reset values. The in-flight command is abandoned; a later eng_done from the engine sets spurious_done_err.

Test Plan:
- Single command: push opcode=0x01, slot=3, addr=0x1000 into an empty queue -> eng_start high 2 edges after the push for exactly 1 cycle, eng_*=0x01/3/0x1000, issued_count=1. eng_done 5 cycles later -> queue_idle=1 one cycle after.
- Fill: with engine done held off, push 5 commands spaced 2 cycles apart (DEPTH=4) -> first one issued, next 4 fill the FIFO, in_ready=0 at level=4, no overflow. A further push -> overflow_err=1 and level stays 4.
- Ordering/wrap: 10 commands with addr=0..9 and engine latency 3 -> eng_dma_addr sequence 0..9 in order, pointers wrap twice, issued_count=10.
- Simultaneous push/pop: level=2 in IDLE with a push on the issue edge -> level stays 2 and the pushed entry is issued third.
- Flush: level=3 while BUSY, assert flush together with in_valid -> level=0, pushed entry discarded, in-flight command completes, no further eng_start.
- Errors/reset: eng_done while IDLE -> spurious_done_err=1. Assert rst mid-BUSY -> all outputs return to reset values immediately, asynchronously.
